apb_master_bridge: RTL

//   APB requester. Converts a simple valid/ready command interface into
//   APB3-style transfers (SETUP then ACCESS, waits on PREADY).

---
 rtl/apb_master_bridge.sv | 97 +++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB3 requester: turns a valid/ready command into a SETUP/ACCESS transfer
// and returns read data or a timeout abort on a held response channel.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PSEL      <= 1'b1;
            cmd_ready <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // Slave completion wins over an abort on the same edge.
          if (PREADY) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
